// File: rtl/flag_rle_enc.sv
// Run-length encoder for a binarised pixel stream, with a first-word-fall-through token FIFO.
// Define RLE_MEAN_EN to tag each token with the i_mean of the pixel that started its run.
module flag_rle_enc #(
  parameter int LINE_W = 640,
  parameter int RUN_W  = 10,
  parameter int DEPTH  = 8,
`ifdef RLE_MEAN_EN
  localparam int TW    = RUN_W + 10
`else
  localparam int TW    = RUN_W + 2
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_vld,
  input  logic                   i_flag,
  input  logic [7:0]             i_mean,
  output logic                   o_vld,
  input  logic                   o_rdy,
  output logic [TW-1:0]          o_data,
  output logic                   o_ovf,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int CW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [RUN_W-1:0] MAXRUN   = {RUN_W{1'b1}};
  localparam logic [CW-1:0]    LAST_COL = CW'(LINE_W - 1);
  localparam logic [AW:0]      FULL_LVL = (AW + 1)'(DEPTH);

  function automatic logic run_sat(input logic [RUN_W-1:0] c);
    return c == (MAXRUN - 1'b1);
  endfunction

`ifdef RLE_MEAN_EN
  function automatic logic [TW-1:0] mk_tok(input logic [7:0] m, input logic e,
                                           input logic f, input logic [RUN_W-1:0] r);
    return {m, e, f, r};
  endfunction
`else
  function automatic logic [TW-1:0] mk_tok(input logic [7:0] unused_m, input logic e,
                                           input logic f, input logic [RUN_W-1:0] r);
    return {e, f, r};
  endfunction
`endif

  logic [CW-1:0]    col, col_nx;
  logic [RUN_W-1:0] cnt, cnt_nx;
  logic             cur_flag, flag_nx;
  logic             pend_vld, pend_vld_nx;
  logic [TW-1:0]    pend, pend_nx;
  logic             push, eol;
  logic [TW-1:0]    push_tok;
  logic [7:0]       run_mean;

  logic [TW-1:0]    mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             full, pop, push_ok, drop;

`ifdef RLE_MEAN_EN
  logic [7:0] mean_r;
  logic       run_start;
  assign run_start = i_vld & ((cnt == '0) | (i_flag != cur_flag));
  assign run_mean  = mean_r;

  always_ff @(posedge clk) begin
    if (run_start) mean_r <= i_mean;
  end
`else
  assign run_mean = '0;
`endif

  // Run tracking: at most one token is produced per edge
  always_comb begin
    push        = 1'b0;
    push_tok    = '0;
    col_nx      = col;
    cnt_nx      = cnt;
    flag_nx     = cur_flag;
    pend_vld_nx = 1'b0;
    pend_nx     = pend;
    eol         = (col == LAST_COL);
    if (pend_vld) begin
      push     = 1'b1;
      push_tok = pend;
    end
    if (i_vld) begin
      col_nx = eol ? '0 : col + 1'b1;
      if (cnt == '0) begin
        flag_nx = i_flag;
        cnt_nx  = eol ? '0 : RUN_W'(1);
        if (eol) begin
          push     = 1'b1;
          push_tok = mk_tok(i_mean, 1'b1, i_flag, RUN_W'(1));
        end
      end else if (i_flag == cur_flag) begin
        if (run_sat(cnt)) begin
          push     = 1'b1;
          push_tok = mk_tok(run_mean, eol, cur_flag, MAXRUN);
          cnt_nx   = '0;
        end else if (eol) begin
          push     = 1'b1;
          push_tok = mk_tok(run_mean, 1'b1, cur_flag, cnt + 1'b1);
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end else begin
        push     = 1'b1;
        push_tok = mk_tok(run_mean, 1'b0, cur_flag, cnt);
        flag_nx  = i_flag;
        // A one-pixel run that also ends the line is emitted on the following edge
        if (eol) begin
          pend_vld_nx = 1'b1;
          pend_nx     = mk_tok(i_mean, 1'b1, i_flag, RUN_W'(1));
          cnt_nx      = '0;
        end else begin
          cnt_nx = RUN_W'(1);
        end
      end
    end
  end

  assign o_level = wr_ptr - rd_ptr;
  assign o_vld   = (o_level != '0);
  assign o_data  = o_vld ? mem[rd_ptr[AW-1:0]] : '0;
  assign full    = (o_level == FULL_LVL);
  assign pop     = o_vld & o_rdy;
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      col      <= '0;
      cnt      <= '0;
      cur_flag <= 1'b0;
      pend_vld <= 1'b0;
      pend     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      o_ovf    <= 1'b0;
    end else begin
      col      <= col_nx;
      cnt      <= cnt_nx;
      cur_flag <= flag_nx;
      pend_vld <= pend_vld_nx;
      pend     <= pend_nx;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (drop)    o_ovf  <= 1'b1;
    end
  end

  // Storage; a full FIFO popping this edge can reuse the freed slot
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr[AW-1:0]] <= push_tok;
  end

endmodule

// File: tb/tb_flag_rle_enc.sv
// Bench for flag_rle_enc: directed line scenarios plus randomized lines against a run-splitting model.
module tb_flag_rle_enc;
`ifdef RLE_MEAN_EN
  localparam int TW = 14;
`else
  localparam int TW = 6;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, i_vld, i_flag, o_rdy;
  logic [7:0] i_mean;
  logic o_vld8, o_ovf8, o_vld40, o_ovf40;
  logic [TW-1:0] o_data8, o_data40;
  logic [2:0] o_level8, o_level40;

  flag_rle_enc #(.LINE_W(8), .RUN_W(4), .DEPTH(4)) dut8 (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_flag(i_flag), .i_mean(i_mean),
    .o_vld(o_vld8), .o_rdy(o_rdy), .o_data(o_data8), .o_ovf(o_ovf8), .o_level(o_level8));

  flag_rle_enc #(.LINE_W(40), .RUN_W(4), .DEPTH(4)) dut40 (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_flag(i_flag), .i_mean(i_mean),
    .o_vld(o_vld40), .o_rdy(o_rdy), .o_data(o_data40), .o_ovf(o_ovf40), .o_level(o_level40));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [TW-1:0] got8[$], got40[$], exp8[$], exp40[$];
  logic [5:0]    e[$];
  logic          pf[$];
  logic [7:0]    pm[$];

  always @(negedge clk) begin
    if (o_vld8 && o_rdy)  got8.push_back(o_data8);
    if (o_vld40 && o_rdy) got40.push_back(o_data40);
  end

  task automatic pix(input logic f, input logic [7:0] m);
    i_vld = 1'b1; i_flag = f; i_mean = m;
    @(posedge clk); #1;
    i_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset;
    rst = 1'b1; i_vld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    got8.delete(); got40.delete();
  endtask

  // Compare {eol,flag,run} of captured tokens against the list in e
  task automatic chk_low(input string tag, input int sel);
    logic [5:0] v;
    int n;
    n = (sel == 8) ? got8.size() : got40.size();
    chk({tag, "_count"}, n, e.size());
    foreach (e[i]) begin
      if (i < n) v = (sel == 8) ? got8[i][5:0] : got40[i][5:0];
      else       v = 6'bx;
      chk($sformatf("%s_tok%0d", tag, i), v, e[i]);
    end
  endtask

  function automatic logic [TW-1:0] pack(input logic [7:0] m, input logic eo,
                                         input logic f, input int n);
    logic [TW+7:0] w;
    w = {m, eo, f, 4'(n)};
    return w[TW-1:0];
  endfunction

  // Reference: split each line into maximal equal-flag runs, chop runs into
  // chunks of at most 15, mark the chunk that reaches the end of line.
  task automatic build_exp(input int lw, output logic [TW-1:0] q[$]);
    q.delete();
    for (int s = 0; s + lw <= pf.size(); s += lw) begin
      int i;
      i = s;
      while (i < s + lw) begin
        int j, pos, n;
        j = i;
        while (j < s + lw && pf[j] == pf[i]) j++;
        pos = i;
        while (pos < j) begin
          n = (j - pos > 15) ? 15 : j - pos;
          q.push_back(pack(pm[pos], (pos + n == s + lw), pf[i], n));
          pos += n;
        end
        i = j;
      end
    end
  endtask

  task automatic set_rdy;
    o_rdy = (o_level8 < 2 && o_level40 < 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  initial begin
    logic f;
    logic [7:0] m;
    logic [TW-1:0] v;
    int thr, t;
    rst = 1'b1; i_vld = 1'b0; i_flag = 1'b0; i_mean = 8'h00; o_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_vld8", o_vld8, 0);    chk("rst_data8", o_data8, 0);
    chk("rst_ovf8", o_ovf8, 0);    chk("rst_lvl8", o_level8, 0);
    chk("rst_vld40", o_vld40, 0);  chk("rst_data40", o_data40, 0);
    chk("rst_ovf40", o_ovf40, 0);  chk("rst_lvl40", o_level40, 0);

    // Two runs in one line
    do_reset;
    foreach (e[i]) e.delete(i);
    e.delete();
    pix(0, 0); pix(0, 0); pix(0, 0);
    repeat (5) pix(1, 0);
    idle(3);
    e.push_back(6'h03); e.push_back(6'h35);
    chk_low("two_runs", 8);

    // Run change on the last pixel: pending token on the next edge
    do_reset;
    repeat (7) pix(0, 0);
    pix(1, 0);
    chk("pend_first_vld", o_vld8, 1);
    chk("pend_first_tok", o_data8[5:0], 6'h07);
    idle(1);
    chk("pend_second_vld", o_vld8, 1);
    chk("pend_second_tok", o_data8[5:0], 6'h31);
    chk("pend_ovf", o_ovf8, 0);

    // Saturation on a 40-pixel line
    do_reset;
    repeat (40) pix(1, 0);
    idle(4);
    e.delete();
    e.push_back(6'h1F); e.push_back(6'h1F); e.push_back(6'h3A);
    chk_low("sat40", 40);

    // Overflow with consumer stalled
    do_reset;
    o_rdy = 1'b0;
    pix(0, 0); pix(0, 0); pix(1, 0); pix(0, 0);
    pix(1, 0); pix(1, 0); pix(0, 0); pix(0, 0);
    idle(2);
    chk("ovf_level", o_level8, 4);
    chk("ovf_flag", o_ovf8, 1);
    got8.delete();
    o_rdy = 1'b1;
    idle(8);
    e.delete();
    e.push_back(6'h02); e.push_back(6'h11); e.push_back(6'h01); e.push_back(6'h12);
    chk_low("ovf_drain", 8);
    chk("ovf_sticky", o_ovf8, 1);
    chk("ovf_empty", o_level8, 0);

    // Reset mid-line, pixel strobe during reset ignored
    do_reset;
    pix(1, 0); pix(1, 0); pix(1, 0);
    rst = 1'b1; i_vld = 1'b1; i_flag = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; i_vld = 1'b0;
    chk("mid_rst_vld", o_vld8, 0);   chk("mid_rst_data", o_data8, 0);
    chk("mid_rst_ovf", o_ovf8, 0);   chk("mid_rst_lvl", o_level8, 0);
    got8.delete();
    repeat (8) pix(0, 0);
    idle(3);
    e.delete();
    e.push_back(6'h28);
    chk_low("after_rst", 8);

    // Randomized lines, both line widths fed the same pixels
    do_reset;
    pf.delete(); pm.delete();
    f = 1'b0;
    for (int b = 0; b < 5; b++) begin
      thr = (b % 3 == 0) ? 8 : (b % 3 == 1) ? 1 : 0;
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(0, 2) == 0) begin set_rdy(); idle(1); end
        if ($urandom_range(0, 15) < thr) f = ~f;
        m = 8'($urandom_range(0, 255));
        pf.push_back(f); pm.push_back(m);
        set_rdy();
        pix(f, m);
      end
    end
    o_rdy = 1'b1;
    idle(2);
    t = 0;
    while ((o_level8 != 0 || o_level40 != 0) && t < 50) begin idle(1); t++; end
    chk("rand_drain_timeout", (t < 50), 1);
    build_exp(8, exp8);
    build_exp(40, exp40);
    chk("rand8_count", got8.size(), exp8.size());
    foreach (exp8[i]) begin
      v = (i < got8.size()) ? got8[i] : 'x;
      chk($sformatf("rand8_tok%0d", i), v, exp8[i]);
    end
    chk("rand40_count", got40.size(), exp40.size());
    foreach (exp40[i]) begin
      v = (i < got40.size()) ? got40[i] : 'x;
      chk($sformatf("rand40_tok%0d", i), v, exp40[i]);
    end
    chk("rand8_ovf", o_ovf8, 0);
    chk("rand40_ovf", o_ovf40, 0);

`ifdef RLE_MEAN_EN
    // Mean of the run-starting pixel is kept even as i_mean changes
    do_reset;
    pix(0, 8'h40);
    for (int k = 1; k < 8; k++) pix(0, 8'(k * 17));
    idle(3);
    chk("mean_count", got8.size(), 1);
    v = (got8.size() > 0) ? got8[0] : 'x;
    chk("mean_tok", v, {8'h40, 6'h28});

    do_reset;
    for (int k = 0; k < 7; k++) pix(0, 8'(8'h10 + k));
    pix(1, 8'h99);
    idle(3);
    chk("mean_pend_count", got8.size(), 2);
    v = (got8.size() > 0) ? got8[0] : 'x;
    chk("mean_pend_tok0", v, {8'h10, 6'h07});
    v = (got8.size() > 1) ? got8[1] : 'x;
    chk("mean_pend_tok1", v, {8'h99, 6'h31});
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/flag_rle_enc.md
FLAG_RLE_ENC -- requirements
Module: flag_rle_enc

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk, rising-edge; rst, sampled only on rising clk.
REQ-002 Parameter LINE_W SHALL default to 640 and set pixels per line; legal values are at least 2.
REQ-003 Parameter RUN_W SHALL default to 10 and set the run-length field width; legal values are at least 2; MAXRUN = 2^RUN_W-1.
REQ-004 Parameter DEPTH SHALL default to 8 and set the output FIFO depth in tokens; it SHALL be a power of 2 and at least 2.
REQ-005 Port clk SHALL be an input, 1 bit: system clock.
REQ-006 Port rst SHALL be an input, 1 bit: synchronous active-high reset.
REQ-007 Port i_vld SHALL be an input, 1 bit: pixel strobe from the thresholding stage; it has no backpressure.
REQ-008 Port i_flag SHALL be an input, 1 bit: binarised pixel.
REQ-009 Port i_mean SHALL be an input, 8 bits: running mean accompanying the pixel.
REQ-010 Port o_vld SHALL be an output, 1 bit: token available.
REQ-011 Port o_rdy SHALL be an input, 1 bit: the consumer accepts a token.
REQ-012 Port o_data SHALL be an output, TW bits: token.
REQ-013 Port o_ovf SHALL be an output, 1 bit: sticky token-drop flag.
REQ-014 Port o_level SHALL be an output, $clog2(DEPTH)+1 bits: FIFO occupancy.

Function
REQ-015 Token layout SHALL be {eol, flag, run[RUN_W-1:0]}, so TW = RUN_W+2; run SHALL be the pixel count, 1..MAXRUN, and never 0.
REQ-016 The block SHALL hold col (0..LINE_W-1), cnt (0..MAXRUN), cur_flag, and one pending-token register, pend.
REQ-017 On an accepted pixel with cnt=0, the block SHALL set cur_flag=i_flag and cnt=1.
REQ-018 On an accepted pixel with cnt>0 and i_flag equal to cur_flag, the block SHALL increment cnt.
REQ-019 On an accepted pixel with cnt>0 and i_flag different from cur_flag, the block SHALL push {0,cur_flag,cnt}, set cur_flag=i_flag, and set cnt=1.
REQ-020 When an accepted pixel makes cnt+1 equal MAXRUN, the block SHALL push {eolbit,cur_flag,MAXRUN} and set cnt=0.
REQ-021 When an accepted pixel has col=LINE_W-1, the block SHALL push the run that includes this pixel with eol=1, set cnt=0, and set col=0; otherwise col SHALL increment.
REQ-022 If a single pixel both closes the previous run (REQ-019) and ends the line, the block SHALL push the old run on that edge, load {1,i_flag,1} into pend, and push pend on the next edge.
REQ-023 An edge that drains pend SHALL never coincide with another push, given LINE_W>=2 and RUN_W>=2.
REQ-024 Saturation coinciding with end of line SHALL produce exactly one token, {1,flag,MAXRUN}.
REQ-025 The FIFO SHALL be first-word-fall-through: a token pushed into an empty FIFO at edge N SHALL appear on o_data with o_vld=1 from edge N.
REQ-026 A token SHALL be popped at each edge where o_vld and o_rdy are both 1.
REQ-027 A push and a pop on the same edge SHALL both take effect, including when the FIFO is full.
REQ-028 A push when full with no pop SHALL drop the new token, set o_ovf=1, and leave stored tokens unchanged.
REQ-029 o_ovf SHALL stay set until rst.
REQ-030 o_data SHALL be 0 whenever o_vld=0.
REQ-031 Tokens SHALL leave in push order.

Reset
REQ-032 When rst=1 at an edge, the block SHALL clear col, cnt, cur_flag, pend, FIFO pointers and o_ovf.
REQ-033 After reset, o_vld, o_data, o_ovf and o_level SHALL all be 0.
REQ-034 Reset mid-line SHALL discard the partial run and any pending token; the next accepted pixel SHALL be col 0.
REQ-035 i_vld SHALL be ignored during the reset cycle.

Configuration
REQ-036 Macro RLE_MEAN_EN SHALL control mean tagging; with it defined, TW = RUN_W+10 and the token SHALL be {mean, eol, flag, run}.
REQ-037 With RLE_MEAN_EN defined, mean SHALL be the i_mean value captured on the pixel that started the run; pend-generated tokens SHALL carry that pixel's i_mean.
REQ-038 Without RLE_MEAN_EN, the block SHALL have no mean register, TW = RUN_W+2, and i_mean SHALL be unused.

Verification (LINE_W=8, RUN_W=4, DEPTH=4, o_rdy=1 unless stated)
REQ-039 The bench SHALL drive flags 0,0,0,1,1,1,1,1 and require tokens {0,0,3} then {1,1,5}.
REQ-040 The bench SHALL drive flags 0x7 then 1 and require {0,0,7} and {1,1,1} on consecutive edges, with o_ovf=0.
REQ-041 The bench SHALL set LINE_W=40 and drive all ones, requiring {0,1,15}, {0,1,15}, {1,1,10}.
REQ-042 The bench SHALL hold o_rdy=0 while 5 tokens are generated, requiring o_level=4 and o_ovf=1; after raising o_rdy, exactly the first 4 tokens SHALL emerge in order.
REQ-043 The bench SHALL assert rst after 3 pixels of a line, requiring all outputs 0 and the next 8 pixels to form one complete line with eol on the 8th.
REQ-044 With RLE_MEAN_EN defined, the bench SHALL start a run at i_mean=0x40 and vary i_mean inside the run, requiring the token mean field to equal 0x40.
